regfile_wb_arbiter: RTL and testbench

//  - Shares the single register-file write port between two writeback requesters:
//    ALU results (alu_*) and load data returning from memory (mem_*).
//  - Arbitrates per cycle using valid/ready handshakes and drives a registered write to the register file.
//  - Exports a one-hot 'pending' mask of the register being written next edge, for hazard/stall logic.

---
 rtl/regfile_wb_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Shares the single register-file write port between two writeback
//   requesters: ALU results (alu_*) and load data returning from memory
//   (mem_*). One request is granted per cycle through valid/ready
//   handshakes. The granted write is registered and presented to the
//   register file on the following cycle. A one-hot mask of the register
//   being written is exported for hazard/stall logic.
//
// Parameters:
//   ARB_MODE  0 = round-robin on conflict
//             1 = mem priority, ALU wins a tie after MAX_WAIT lost cycles
//   MAX_WAIT  ARB_MODE=1 only, 1..15
//
// Optional feature:
//   REGFILE_ARB_STATS_EN  when defined, adds o_conflict_count, a saturating
//                         count of cycles in which both requesters are valid.
//
// Ports:
//   i_clk             clock, all state on the rising edge
//   i_rst             synchronous, active-low reset
//   i_alu_valid       ALU writeback request
//   o_alu_ready       ALU request granted this cycle (combinational)
//   i_alu_addr[4:0]   ALU destination register
//   i_alu_data[31:0]  ALU result
//   i_mem_valid       load writeback request
//   o_mem_ready       load request granted this cycle (combinational)
//   i_mem_addr[4:0]   load destination register
//   i_mem_data[31:0]  load data
//   o_wr_ena          register-file write enable (registered)
//   o_wr_addr[4:0]    register-file write address (registered)
//   o_wr_data[31:0]   register-file write data (registered)
//   o_pending[31:0]   one-hot of o_wr_addr when o_wr_ena=1, else 0
//   o_conflict_count  [15:0], only with REGFILE_ARB_STATS_EN
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int ARB_MODE = 0,
    parameter int MAX_WAIT = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [4:0]  i_alu_addr,
    input  logic [31:0] i_alu_data,
    input  logic        i_mem_valid,
    output logic        o_mem_ready,
    input  logic [4:0]  i_mem_addr,
    input  logic [31:0] i_mem_data,
    output logic        o_wr_ena,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_pending
`ifdef REGFILE_ARB_STATS_EN
    ,
    output logic [15:0] o_conflict_count
`endif
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    grant_e      r_last_grant;
    logic [3:0]  r_age;
    logic        r_wr_ena;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;

    logic        w_conflict;
    logic        w_alu_wins;
    logic        w_alu_xfer;
    logic        w_mem_xfer;
    logic        w_any_xfer;
    logic [4:0]  w_sel_addr;
    logic [31:0] w_sel_data;

    // Grant decision. Only the valids and arbitration state feed the readies,
    // never addr/data. Both readies are forced low while reset is asserted,
    // so requests presented during reset are ignored.
    always_comb begin
        w_conflict = i_alu_valid & i_mem_valid;
        if (ARB_MODE == 1) begin
            // Memory normally wins a tie; a starved ALU wins once it has
            // lost MAX_WAIT consecutive cycles.
            w_alu_wins = (r_age == LP_MAX_WAIT);
        end else begin
            w_alu_wins = (r_last_grant == GRANT_MEM);
        end
        w_alu_xfer = i_rst & i_alu_valid & (~w_conflict | w_alu_wins);
        w_mem_xfer = i_rst & i_mem_valid & (~w_conflict | ~w_alu_wins);
        w_any_xfer = w_alu_xfer | w_mem_xfer;
        w_sel_addr = w_alu_xfer ? i_alu_addr : i_mem_addr;
        w_sel_data = w_alu_xfer ? i_alu_data : i_mem_data;
    end

    // Registered write port and arbitration state. A transfer to x0 is
    // consumed like any other but never raises the write enable. With no
    // transfer, address and data hold so the register file sees a quiet bus.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_wr_ena     <= 1'b0;
            r_wr_addr    <= 5'd0;
            r_wr_data    <= 32'd0;
            r_last_grant <= GRANT_MEM;
            r_age        <= 4'd0;
        end else begin
            r_wr_ena <= w_any_xfer && (w_sel_addr != 5'd0);
            if (w_any_xfer) begin
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
            end

            // Round-robin history tracks every transfer, not just ties.
            if (w_alu_xfer) begin
                r_last_grant <= GRANT_ALU;
            end else if (w_mem_xfer) begin
                r_last_grant <= GRANT_MEM;
            end

            // Age counts consecutive cycles the ALU waited with valid high.
            if (!i_alu_valid || w_alu_xfer) begin
                r_age <= 4'd0;
            end else if (r_age != LP_MAX_WAIT) begin
                r_age <= r_age + 4'd1;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] r_conflict_count;

    // Counts cycles with both requesters valid, saturating at all-ones.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_conflict_count <= 16'd0;
        end else if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
            r_conflict_count <= r_conflict_count + 16'd1;
        end
    end

    assign o_conflict_count = r_conflict_count;
`endif

    assign o_alu_ready = w_alu_xfer;
    assign o_mem_ready = w_mem_xfer;
    assign o_wr_ena    = r_wr_ena;
    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_pending   = r_wr_ena ? (32'd1 << r_wr_addr) : 32'd0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. Two instances share the stimulus:
// dut0 uses round-robin arbitration, dut1 uses mem priority with ALU aging
// (MAX_WAIT=3). Each directed step drives one cycle of requests, checks the
// readies, pushes the expected registered write onto a scoreboard queue and
// pops it after the clock edge to compare against the write port.
module tb_regfile_wb_arbiter;

   localparam int G_NONE = 0;
   localparam int G_ALU  = 1;
   localparam int G_MEM  = 2;

   typedef struct {
      logic        ena;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] pend;
      logic        chkAddrData;
   } wbExp_t;

   logic        clk;
   logic        rst;
   logic        aluValid;
   logic [4:0]  aluAddr;
   logic [31:0] aluData;
   logic        memValid;
   logic [4:0]  memAddr;
   logic [31:0] memData;

   logic        d0AluReady, d0MemReady, d0WrEna;
   logic [4:0]  d0WrAddr;
   logic [31:0] d0WrData, d0Pending;
   logic        d1AluReady, d1MemReady, d1WrEna;
   logic [4:0]  d1WrAddr;
   logic [31:0] d1WrData, d1Pending;
`ifdef REGFILE_ARB_STATS_EN
   logic [15:0] d0ConflictCount, d1ConflictCount;
`endif

   logic        selDut;
   logic        obsAluReady, obsMemReady, obsWrEna;
   logic [4:0]  obsWrAddr;
   logic [31:0] obsWrData, obsPending;

   int          vectorsApplied = 0;
   int          miscompares    = 0;
   wbExp_t      expQ[$];
   logic [4:0]  lastAddr;
   logic [31:0] lastData;
   logic        holdKnown;

   regfile_wb_arbiter #(.ARB_MODE(0), .MAX_WAIT(3)) dut0 (
      .i_clk(clk), .i_rst(rst),
      .i_alu_valid(aluValid), .o_alu_ready(d0AluReady),
      .i_alu_addr(aluAddr), .i_alu_data(aluData),
      .i_mem_valid(memValid), .o_mem_ready(d0MemReady),
      .i_mem_addr(memAddr), .i_mem_data(memData),
      .o_wr_ena(d0WrEna), .o_wr_addr(d0WrAddr), .o_wr_data(d0WrData),
      .o_pending(d0Pending)
`ifdef REGFILE_ARB_STATS_EN
      , .o_conflict_count(d0ConflictCount)
`endif
   );

   regfile_wb_arbiter #(.ARB_MODE(1), .MAX_WAIT(3)) dut1 (
      .i_clk(clk), .i_rst(rst),
      .i_alu_valid(aluValid), .o_alu_ready(d1AluReady),
      .i_alu_addr(aluAddr), .i_alu_data(aluData),
      .i_mem_valid(memValid), .o_mem_ready(d1MemReady),
      .i_mem_addr(memAddr), .i_mem_data(memData),
      .o_wr_ena(d1WrEna), .o_wr_addr(d1WrAddr), .o_wr_data(d1WrData),
      .o_pending(d1Pending)
`ifdef REGFILE_ARB_STATS_EN
      , .o_conflict_count(d1ConflictCount)
`endif
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Route the outputs of whichever instance is under test to the checker.
   always_comb begin
      obsAluReady = selDut ? d1AluReady : d0AluReady;
      obsMemReady = selDut ? d1MemReady : d0MemReady;
      obsWrEna    = selDut ? d1WrEna    : d0WrEna;
      obsWrAddr   = selDut ? d1WrAddr   : d0WrAddr;
      obsWrData   = selDut ? d1WrData   : d0WrData;
      obsPending  = selDut ? d1Pending  : d0Pending;
   end

   // One comparison: counts it, and on mismatch counts and reports it.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectorsApplied++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // One cycle of stimulus. expGrant says which requester must be granted;
   // the resulting write is queued and checked after the clock edge.
   task automatic applyStimulus(input logic rstN,
                                input logic aV, input logic [4:0] aA, input logic [31:0] aD,
                                input logic mV, input logic [4:0] mA, input logic [31:0] mD,
                                input int expGrant, input string tag);
      wbExp_t e;
      wbExp_t got;
      @(negedge clk);
      rst      = rstN;
      aluValid = aV;
      aluAddr  = aA;
      aluData  = aD;
      memValid = mV;
      memAddr  = mA;
      memData  = mD;
      #1;
      checkOutput({tag, "/alu_ready"}, 32'(obsAluReady), 32'(expGrant == G_ALU));
      checkOutput({tag, "/mem_ready"}, 32'(obsMemReady), 32'(expGrant == G_MEM));

      if (!rstN) begin
         e.ena = 1'b0; e.addr = 5'd0; e.data = 32'd0; e.chkAddrData = 1'b1;
         lastAddr = 5'd0; lastData = 32'd0; holdKnown = 1'b1;
      end else if (expGrant == G_ALU) begin
         e.ena = (aA != 5'd0); e.addr = aA; e.data = aD; e.chkAddrData = (aA != 5'd0);
         lastAddr = aA; lastData = aD; holdKnown = (aA != 5'd0);
      end else if (expGrant == G_MEM) begin
         e.ena = (mA != 5'd0); e.addr = mA; e.data = mD; e.chkAddrData = (mA != 5'd0);
         lastAddr = mA; lastData = mD; holdKnown = (mA != 5'd0);
      end else begin
         e.ena = 1'b0; e.addr = lastAddr; e.data = lastData; e.chkAddrData = holdKnown;
      end
      e.pend = e.ena ? (32'd1 << e.addr) : 32'd0;
      expQ.push_back(e);

      @(posedge clk);
      #1;
      if (expQ.size() == 0) begin
         checkOutput({tag, "/scoreboard_empty"}, 32'd1, 32'd0);
      end else begin
         got = expQ.pop_front();
         checkOutput({tag, "/wr_ena"}, 32'(obsWrEna), 32'(got.ena));
         checkOutput({tag, "/pending"}, obsPending, got.pend);
         if (got.chkAddrData) begin
            checkOutput({tag, "/wr_addr"}, 32'(obsWrAddr), 32'(got.addr));
            checkOutput({tag, "/wr_data"}, obsWrData, got.data);
         end
      end
   endtask

   initial begin
      selDut    = 1'b0;
      rst       = 1'b0;
      aluValid  = 1'b0;
      aluAddr   = 5'd0;
      aluData   = 32'd0;
      memValid  = 1'b0;
      memAddr   = 5'd0;
      memData   = 32'd0;
      lastAddr  = 5'd0;
      lastData  = 32'd0;
      holdKnown = 1'b1;
      $display("[TB] start");

      // Reset held two cycles with both requesters valid.
      applyStimulus(0, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, G_NONE, "rst0");
      applyStimulus(0, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, G_NONE, "rst1");

      // Round-robin conflict, ALU first after reset, one write per cycle.
      applyStimulus(1, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, G_ALU, "rr0");
      applyStimulus(1, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, G_MEM, "rr1");
      applyStimulus(1, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, G_ALU, "rr2");
      applyStimulus(1, 1, 5'd1, 32'h1111_1111, 1, 5'd2, 32'h2222_2222, G_MEM, "rr3");

      // Idle: no write, address and data hold.
      applyStimulus(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, G_NONE, "idle0");

      // Single ALU request.
      applyStimulus(1, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'd0, G_ALU, "aluOnly");

      // Last grant was the (non-conflict) ALU transfer, so mem wins the tie.
      applyStimulus(1, 1, 5'd6, 32'h0000_0006, 1, 5'd7, 32'h0000_0007, G_MEM, "rrAfterSingle");
      applyStimulus(1, 0, 5'd0, 32'd0, 1, 5'd8, 32'h0000_0008, G_MEM, "memOnly");
      applyStimulus(1, 1, 5'd6, 32'h0000_0006, 1, 5'd7, 32'h0000_0007, G_ALU, "rrAfterMem");

      // x0 load is consumed without a write.
      applyStimulus(1, 0, 5'd0, 32'd0, 1, 5'd0, 32'h0000_1234, G_MEM, "x0drop");

      // Same destination from both sides: winner first, loser later.
      applyStimulus(1, 1, 5'd9, 32'h0000_000A, 1, 5'd9, 32'h0000_000B, G_ALU, "sameAddr0");
      applyStimulus(1, 0, 5'd0, 32'd0, 1, 5'd9, 32'h0000_000B, G_MEM, "sameAddr1");
      applyStimulus(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, G_NONE, "idle1");

      // Reset mid-operation drops the write and restores last_grant.
      applyStimulus(1, 1, 5'd10, 32'h0000_0010, 0, 5'd0, 32'd0, G_ALU, "preRst");
      applyStimulus(0, 1, 5'd11, 32'h0000_0011, 1, 5'd12, 32'h0000_0012, G_NONE, "midRst");
      applyStimulus(1, 1, 5'd11, 32'h0000_0011, 1, 5'd12, 32'h0000_0012, G_ALU, "postRst");

      // Aging instance: mem,mem,mem,alu repeating under continuous conflict.
      selDut = 1'b1;
      applyStimulus(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, G_NONE, "ageRst");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1, 1, 5'd3, 32'h0000_0C0C, 1, 5'd4, 32'h0000_0D0D,
                       ((k % 4) == 3) ? G_ALU : G_MEM, $sformatf("age%0d", k));
      end
      selDut = 1'b0;

`ifdef REGFILE_ARB_STATS_EN
      // Conflict statistics: 10 cycles, then saturation.
      applyStimulus(0, 1, 5'd1, 32'd1, 1, 5'd2, 32'd2, G_NONE, "statRst");
      checkOutput("stat/reset", 32'(d0ConflictCount), 32'd0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         rst = 1'b1; aluValid = 1'b1; memValid = 1'b1;
      end
      @(posedge clk);
      #1;
      checkOutput("stat/ten", 32'(d0ConflictCount), 32'd10);
      checkOutput("stat/tenMode1", 32'(d1ConflictCount), 32'd10);
      for (int k = 0; k < 69990; k++) begin
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      checkOutput("stat/saturate", 32'(d0ConflictCount), 32'h0000_FFFF);
      checkOutput("stat/saturateMode1", 32'(d1ConflictCount), 32'h0000_FFFF);
      @(negedge clk);
      aluValid = 1'b0; memValid = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
      $finish;
   end

endmodule
